// File: rtl/fetch_queue_pkg.sv
// Shared types for the dual-wide fetch queue: the stored PC/IR entry and the default depth.
package fetch_queue_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned FQ_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } fq_entry_t;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue.sv
// Dual-wide in-order instruction buffer between fetch and decode, with flush.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency empty-queue bypass onto the outputs.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             flush,
    input  logic             in_valid_0,
    input  logic             in_valid_1,
    input  logic [XLEN-1:0]  in_pc_0,
    input  logic [XLEN-1:0]  in_pc_1,
    input  logic [XLEN-1:0]  in_ir_0,
    input  logic [XLEN-1:0]  in_ir_1,
    output logic             in_ready,
    output logic             out_valid_0,
    output logic             out_valid_1,
    output logic [XLEN-1:0]  out_pc_0,
    output logic [XLEN-1:0]  out_pc_1,
    output logic [XLEN-1:0]  out_ir_0,
    output logic [XLEN-1:0]  out_ir_1,
    input  logic [1:0]       deq_cnt,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fq_entry_t        mem_q [DEPTH];

    logic             push_c;
    logic [CNT_W-1:0] push_n_c;
    logic [CNT_W-1:0] pop_n_c;
    logic [CNT_W-1:0] deq_w_c;
    logic [CNT_W-1:0] avail_c;
    fq_entry_t        head0_c, head1_c;

    // Push/pop amounts; ready depends on registered occupancy only.
    always_comb begin
        in_ready = (count_q <= CNT_W'(DEPTH - 2));
        push_c   = in_valid_0 & in_ready & ~flush;
        push_n_c = '0;
        if (push_c) begin
            push_n_c = in_valid_1 ? CNT_W'(2) : CNT_W'(1);
        end
        deq_w_c = CNT_W'(deq_cnt);
`ifdef FETCH_QUEUE_BYPASS_EN
        // Empty queue: decode may consume straight from this cycle's fetch slots.
        avail_c = (count_q == '0) ? push_n_c : count_q;
`else
        avail_c = count_q;
`endif
        pop_n_c = (deq_w_c > avail_c) ? avail_c : deq_w_c;
    end

    // Next-state pointer and occupancy; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_n_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_n_c);
        count_d  = count_q + push_n_c - pop_n_c;
        if (flush) begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is intentionally not cleared by reset.
    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{pc: in_pc_0, ir: in_ir_0};
            if (in_valid_1) begin
                mem_q[wr_ptr_q + PTR_W'(1)] <= '{pc: in_pc_1, ir: in_ir_1};
            end
        end
    end

    always_comb begin
        head0_c     = mem_q[rd_ptr_q];
        head1_c     = mem_q[rd_ptr_q + PTR_W'(1)];
        out_valid_0 = (count_q >= CNT_W'(1));
        out_valid_1 = (count_q >= CNT_W'(2));
`ifdef FETCH_QUEUE_BYPASS_EN
        if ((count_q == '0) && !flush) begin
            out_valid_0 = in_valid_0;
            out_valid_1 = in_valid_0 & in_valid_1;
            head0_c     = '{pc: in_pc_0, ir: in_ir_0};
            head1_c     = '{pc: in_pc_1, ir: in_ir_1};
        end
`endif
        out_pc_0 = out_valid_0 ? head0_c.pc : '0;
        out_ir_0 = out_valid_0 ? head0_c.ir : '0;
        out_pc_1 = out_valid_1 ? head1_c.pc : '0;
        out_ir_1 = out_valid_1 ? head1_c.ir : '0;
        count    = count_q;
        empty    = (count_q == '0);
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (default build): directed scenarios plus random traffic vs a queue model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             CLK, RESET, flush;
    logic             in_valid_0, in_valid_1, in_ready;
    logic [31:0]      in_pc_0, in_pc_1, in_ir_0, in_ir_1;
    logic             out_valid_0, out_valid_1;
    logic [31:0]      out_pc_0, out_pc_1, out_ir_0, out_ir_1;
    logic [1:0]       deq_cnt;
    logic [CNT_W-1:0] count;
    logic             empty;

    int total = 0;
    int bad   = 0;

    logic [63:0] mq [$];

    fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .flush(flush),
        .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
        .in_pc_0(in_pc_0), .in_pc_1(in_pc_1), .in_ir_0(in_ir_0), .in_ir_1(in_ir_1),
        .in_ready(in_ready),
        .out_valid_0(out_valid_0), .out_valid_1(out_valid_1),
        .out_pc_0(out_pc_0), .out_pc_1(out_pc_1), .out_ir_0(out_ir_0), .out_ir_1(out_ir_1),
        .deq_cnt(deq_cnt), .count(count), .empty(empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] irof(input logic [31:0] pc);
        return pc ^ 32'hA5C3_0F11;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit past it.
    task automatic step(input logic fl, input logic v0, input logic v1,
                        input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] dq);
        int sz, p;
        bit rdy;
        flush = fl; in_valid_0 = v0; in_valid_1 = v1;
        in_pc_0 = p0; in_pc_1 = p1; in_ir_0 = irof(p0); in_ir_1 = irof(p1);
        deq_cnt = dq;
        @(posedge CLK);
        sz  = mq.size();
        rdy = (DEPTH - sz) >= 2;
        if (fl) begin
            mq.delete();
        end else begin
            p = (int'(dq) > sz) ? sz : int'(dq);
            repeat (p) void'(mq.pop_front());
            if (v0 && rdy) begin
                mq.push_back({p0, irof(p0)});
                if (v1) mq.push_back({p1, irof(p1)});
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid_0 = 0; in_valid_1 = 0;
        in_pc_0 = 0; in_pc_1 = 0; in_ir_0 = 0; in_ir_1 = 0; deq_cnt = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #1 RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        mq.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b1;
        #12;
        total++;
        if ({in_ready, empty, out_valid_0, out_valid_1, count} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL reset_status got rdy/empty/v0/v1/count=%b%b%b%b/%0d want 1100/0",
                     in_ready, empty, out_valid_0, out_valid_1, count);
        end
        total++;
        if ({out_pc_0, out_pc_1, out_ir_0, out_ir_1} !== 128'd0) begin
            bad++;
            $display("FAIL reset_data got pc0=%h pc1=%h ir0=%h ir1=%h want all 0",
                     out_pc_0, out_pc_1, out_ir_0, out_ir_1);
        end
        @(negedge CLK);
        RESET = 1'b0;
        mq.delete();
        step(0, 1, 1, 32'h00, 32'h04, 0);
        total++;
        if ({out_valid_0, out_valid_1, out_pc_0, out_pc_1, count} !== {1'b1, 1'b1, 32'h00, 32'h04, 4'd2}) begin
            bad++;
            $display("FAIL first_push got v=%b%b pc0=%h pc1=%h count=%0d want v=11 pc0=0 pc1=4 count=2",
                     out_valid_0, out_valid_1, out_pc_0, out_pc_1, count);
        end
        total++;
        if ({out_ir_0, out_ir_1} !== {irof(32'h00), irof(32'h04)}) begin
            bad++;
            $display("FAIL first_push_ir got %h %h want %h %h", out_ir_0, out_ir_1, irof(32'h00), irof(32'h04));
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 32'(8 * k), 32'(8 * k + 4), 0);
            total++;
            if ({count, in_ready} !== {4'(2 * (k + 1)), (k < 3) ? 1'b1 : 1'b0}) begin
                bad++;
                $display("FAIL fill_%0d got count=%0d rdy=%b want count=%0d rdy=%b",
                         k, count, in_ready, 2 * (k + 1), (k < 3));
            end
        end
        step(0, 1, 1, 32'h40, 32'h44, 0);
        total++;
        if ({count, in_ready, out_pc_0} !== {4'd8, 1'b0, 32'h00}) begin
            bad++;
            $display("FAIL full_push_ignored got count=%0d rdy=%b pc0=%h want 8 0 0", count, in_ready, out_pc_0);
        end
        step(0, 0, 0, 0, 0, 1);
        total++;
        if ({count, in_ready} !== {4'd7, 1'b0}) begin
            bad++;
            $display("FAIL count7_not_ready got count=%0d rdy=%b want 7 0", count, in_ready);
        end
        step(0, 1, 1, 32'h48, 32'h4C, 1);
        total++;
        if ({count, in_ready, out_pc_0, out_pc_1} !== {4'd6, 1'b1, 32'h08, 32'h0C}) begin
            bad++;
            $display("FAIL count7_push_dropped got count=%0d rdy=%b pc0=%h pc1=%h want 6 1 8 c",
                     count, in_ready, out_pc_0, out_pc_1);
        end
    endtask

    task automatic test_back_to_back_wrap();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 32'(8 * i), 32'(8 * i + 4), (i == 0) ? 2'd0 : 2'd2);
            if ({out_pc_0, out_pc_1, count} !== {32'(8 * i), 32'(8 * i + 4), 4'd2}) begin
                errs++;
                $display("FAIL wrap_order cycle %0d got pc0=%h pc1=%h count=%0d want %h %h 2",
                         i, out_pc_0, out_pc_1, count, 8 * i, 8 * i + 4);
            end
        end
        total++;
        if (errs != 0) bad++;
        step(0, 0, 0, 0, 0, 2);
        total++;
        if ({count, empty} !== {4'd0, 1'b1}) begin
            bad++;
            $display("FAIL wrap_drain got count=%0d empty=%b want 0 1", count, empty);
        end
    endtask

    task automatic test_flush();
        do_reset();
        step(0, 1, 1, 32'h200, 32'h204, 0);
        step(0, 1, 1, 32'h208, 32'h20C, 0);
        step(0, 1, 0, 32'h210, 32'h0, 0);
        total++;
        if (count !== 4'd5) begin
            bad++;
            $display("FAIL flush_setup got count=%0d want 5", count);
        end
        step(1, 1, 1, 32'h220, 32'h224, 2);
        total++;
        if ({count, empty, out_valid_0, out_valid_1, out_pc_0} !== {4'd0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL flush_clear got count=%0d empty=%b v=%b%b pc0=%h want 0 1 00 0",
                     count, empty, out_valid_0, out_valid_1, out_pc_0);
        end
        step(0, 1, 0, 32'h240, 32'h0, 0);
        total++;
        if ({out_valid_0, out_valid_1, out_pc_0, count} !== {1'b1, 1'b0, 32'h240, 4'd1}) begin
            bad++;
            $display("FAIL flush_after_push got v=%b%b pc0=%h count=%0d want 10 240 1",
                     out_valid_0, out_valid_1, out_pc_0, count);
        end
    endtask

    task automatic test_underflow();
        step(0, 0, 0, 0, 0, 2);
        total++;
        if ({count, empty, out_valid_0} !== {4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL underflow_clamp got count=%0d empty=%b v0=%b want 0 1 0", count, empty, out_valid_0);
        end
        step(0, 1, 1, 32'h300, 32'h304, 0);
        total++;
        if ({out_pc_0, out_pc_1, count} !== {32'h300, 32'h304, 4'd2}) begin
            bad++;
            $display("FAIL underflow_rdptr got pc0=%h pc1=%h count=%0d want 300 304 2", out_pc_0, out_pc_1, count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 1, 1, 32'(32'h400 + 8 * k), 32'(32'h404 + 8 * k), 0);
        total++;
        if (count !== 4'd6) begin
            bad++;
            $display("FAIL areset_setup got count=%0d want 6", count);
        end
        #2 RESET = 1'b1;
        #1;
        total++;
        if ({count, empty, in_ready, out_valid_0, out_valid_1, out_pc_0, out_pc_1}
            !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL areset_immediate got count=%0d empty=%b rdy=%b v=%b%b pc0=%h pc1=%h want 0 1 1 00 0 0",
                     count, empty, in_ready, out_valid_0, out_valid_1, out_pc_0, out_pc_1);
        end
        in_valid_0 = 1; in_valid_1 = 1; in_pc_0 = 32'h500; in_pc_1 = 32'h504;
        @(negedge CLK);
        idle_inputs();
        RESET = 1'b0;
        mq.delete();
        step(0, 1, 1, 32'h600, 32'h604, 0);
        total++;
        if ({out_pc_0, out_pc_1, count} !== {32'h600, 32'h604, 4'd2}) begin
            bad++;
            $display("FAIL areset_resume got pc0=%h pc1=%h count=%0d want 600 604 2", out_pc_0, out_pc_1, count);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc_next = 32'h1000;
        logic [31:0] e_pc0, e_pc1, e_ir0, e_ir1;
        logic        e_v0, e_v1, fl, v0, v1;
        int          sz;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            fl = ($urandom_range(0, 19) == 0);
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 1) == 1);
            step(fl, v0, v1, pc_next, pc_next + 4, 2'($urandom_range(0, 2)));
            pc_next = pc_next + 8;
            sz    = mq.size();
            e_v0  = sz >= 1;
            e_v1  = sz >= 2;
            e_pc0 = e_v0 ? mq[0][63:32] : 32'h0;
            e_ir0 = e_v0 ? mq[0][31:0]  : 32'h0;
            e_pc1 = e_v1 ? mq[1][63:32] : 32'h0;
            e_ir1 = e_v1 ? mq[1][31:0]  : 32'h0;
            total++;
            if ({count, empty, in_ready, out_valid_0, out_valid_1}
                !== {4'(sz), sz == 0, (DEPTH - sz) >= 2, e_v0, e_v1}) begin
                bad++;
                $display("FAIL rand_status cycle %0d got count=%0d empty=%b rdy=%b v=%b%b want count=%0d",
                         i, count, empty, in_ready, out_valid_0, out_valid_1, sz);
            end
            total++;
            if ({out_pc_0, out_ir_0, out_pc_1, out_ir_1} !== {e_pc0, e_ir0, e_pc1, e_ir1}) begin
                bad++;
                $display("FAIL rand_data cycle %0d got %h/%h %h/%h want %h/%h %h/%h",
                         i, out_pc_0, out_ir_0, out_pc_1, out_ir_1, e_pc0, e_ir0, e_pc1, e_ir1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back_wrap();
        test_flush();
        test_underflow();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_queue
